// File: rtl/fb_stream_loader_if.sv
// Byte-stream input and framebuffer write-port bundle for fb_stream_loader.
interface fb_stream_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [7:0]        i_data;
    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] o_addr;
    logic [11:0]       o_wdata;
    logic              o_wr_en;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    // Loader side: consumes the byte stream and drives the framebuffer write port.
    modport master (
        input  i_data, i_valid,
        output o_ready, o_addr, o_wdata, o_wr_en, o_busy, o_done, o_err
    );

    // Stream source / framebuffer side.
    modport slave (
        output i_data, i_valid,
        input  o_ready, o_addr, o_wdata, o_wr_en, o_busy, o_done, o_err
    );
endinterface

// File: rtl/fb_stream_loader.sv
// Framed byte-stream to framebuffer loader.
// Frame: 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 3 bytes per 2 packed
// 12-bit words. One registered write strobe per decoded word, address wraps
// at NUM_WORDS, inter-byte timeout aborts a frame.
module fb_stream_loader #(
    parameter int unsigned NUM_WORDS = 2304,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fb_stream_loader_if.master bus
);

    localparam int unsigned       TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_FINISH
    } state_t;

    state_t            state, state_n;

    logic [1:0]        hdr_idx, hdr_idx_n;
    logic [11:0]       hdr_start, hdr_start_n;
    logic [3:0]        hdr_cnt_hi, hdr_cnt_hi_n;
    logic [11:0]       hdr_count;
    logic              hdr_ok;

    logic [1:0]        phase, phase_n;
    logic [7:0]        b0, b0_n;
    logic [3:0]        nib, nib_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [11:0]       remaining, remaining_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;

    logic              accept;
    logic              do_write;
    logic [11:0]       word;

    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [11:0]       wdata_q, wdata_n;
    logic              wr_en_q, wr_en_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;

    // The only back-pressure is the single FINISH cycle.
    assign accept = bus.i_valid && (state != ST_FINISH);

    // Header check uses the byte on the wire as CNT_LO, so it resolves on that edge.
    assign hdr_count = {hdr_cnt_hi, bus.i_data};
    assign hdr_ok    = (32'(hdr_start) < NUM_WORDS) &&
                       (hdr_count != '0) &&
                       (32'(hdr_count) <= NUM_WORDS);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath updates and next registered output values.
    always_comb begin
        state_n      = state;
        hdr_idx_n    = hdr_idx;
        hdr_start_n  = hdr_start;
        hdr_cnt_hi_n = hdr_cnt_hi;
        phase_n      = phase;
        b0_n         = b0;
        nib_n        = nib;
        wr_addr_n    = wr_addr;
        remaining_n  = remaining;
        tmo_cnt_n    = tmo_cnt;
        do_write     = 1'b0;
        word         = '0;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        wr_en_n      = 1'b0;
        done_n       = 1'b0;
        err_n        = 1'b0;

        case (state)
            ST_IDLE: begin
                tmo_cnt_n = '0;
                if (accept && (bus.i_data == SYNC_BYTE)) begin
                    state_n   = ST_HDR;
                    hdr_idx_n = '0;
                end
            end

            ST_HDR: begin
                if (accept) begin
                    tmo_cnt_n = '0;
                    hdr_idx_n = hdr_idx + 2'd1;
                    case (hdr_idx)
                        2'd0:    hdr_start_n[11:8] = bus.i_data[3:0];
                        2'd1:    hdr_start_n[7:0]  = bus.i_data;
                        2'd2:    hdr_cnt_hi_n      = bus.i_data[3:0];
                        default: begin
                            if (hdr_ok) begin
                                state_n     = ST_DATA;
                                phase_n     = '0;
                                wr_addr_n   = ADDR_W'(hdr_start);
                                remaining_n = hdr_count;
                            end else begin
                                state_n = ST_IDLE;
                                err_n   = 1'b1;
                            end
                        end
                    endcase
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end

            ST_DATA: begin
                if (accept) begin
                    tmo_cnt_n = '0;
                    case (phase)
                        2'd0: begin
                            b0_n    = bus.i_data;
                            phase_n = 2'd1;
                        end
                        2'd1: begin
                            do_write = 1'b1;
                            word     = {b0, bus.i_data[7:4]};
                            nib_n    = bus.i_data[3:0];
                            phase_n  = 2'd2;
                        end
                        default: begin
                            do_write = 1'b1;
                            word     = {nib, bus.i_data};
                            phase_n  = 2'd0;
                        end
                    endcase
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end

            ST_FINISH: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Shared write path for both word positions; the last word ends the frame
        // even if it was word0 of a triple (odd count drops B1's low nibble).
        if (do_write) begin
            wr_en_n     = 1'b1;
            addr_n      = wr_addr;
            wdata_n     = word;
            wr_addr_n   = (wr_addr == ADDR_LAST) ? '0 : wr_addr + ADDR_W'(1);
            remaining_n = remaining - 12'd1;
            if (remaining == 12'd1) begin
                done_n  = 1'b1;
                state_n = ST_FINISH;
            end
        end

        busy_n = (state_n != ST_IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hdr_idx    <= '0;
            hdr_start  <= '0;
            hdr_cnt_hi <= '0;
            phase      <= '0;
            b0         <= '0;
            nib        <= '0;
            wr_addr    <= '0;
            remaining  <= '0;
            tmo_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            hdr_idx    <= hdr_idx_n;
            hdr_start  <= hdr_start_n;
            hdr_cnt_hi <= hdr_cnt_hi_n;
            phase      <= phase_n;
            b0         <= b0_n;
            nib        <= nib_n;
            wr_addr    <= wr_addr_n;
            remaining  <= remaining_n;
            tmo_cnt    <= tmo_cnt_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            wr_en_q    <= wr_en_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    assign bus.o_ready = (state != ST_FINISH);
    assign bus.o_addr  = addr_q;
    assign bus.o_wdata = wdata_q;
    assign bus.o_wr_en = wr_en_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;

endmodule
